// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle sequencer for the MIPS-subset datapath. Steps each instruction
// through fetch / decode / execute / memory / writeback and drives every
// datapath enable and mux select from the state register. FETCH outputs are
// additionally gated by mem_ready so the PC and IR only load once the
// instruction word has actually arrived.
//
// Optional feature: define JUMP_EN to build the JUMP state (opcode 000010).
// Without it, opcode 000010 decodes as illegal and pcsrc never reads 10.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   opcode     in   instr[31:26] from the IR (used in DECODE and MEMADR)
//   mem_ready  in   memory completed the current access this cycle
//   pcwrite    out  unconditional PC load
//   branch     out  PC load qualified by ALU zero
//   iord       out  memory address select (0 = PC, 1 = ALUOut)
//   memwrite   out  memory write strobe
//   irwrite    out  instruction register load
//   memtoreg   out  register write data select (1 = MDR)
//   regdst     out  destination register select (1 = rd)
//   regwrite   out  register file write enable
//   alusrca    out  ALU A select (0 = PC, 1 = A)
//   alusrcb    out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   aluop      out  00 add, 01 sub, 10 use funct
//   pcsrc      out  00 ALU result, 01 ALUOut, 10 jump target
//   illegal    out  pulse during DECODE of an unsupported opcode
//   state      out  current state, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               branch,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10
`ifdef JUMP_EN
        , S_JUMP = 4'd11
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef JUMP_EN
                    OP_J:         w_next = S_JUMP;
`endif
                    default:      w_next = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything that is not lw is a store.
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Output decode. During reset everything reads as a stalled FETCH so no
    // enable can fire regardless of where the state register currently is.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        if (!rst_n) begin
            alusrcb = 2'b01;
        end else begin
            case (r_state)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: illegal = 1'b0;
`ifdef JUMP_EN
                        OP_J:    illegal = 1'b0;
`endif
                        default: illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BEQ: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
`ifdef JUMP_EN
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state = STATE_W'(r_state);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the MIPS-subset datapath. It steps each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath enable and mux select from a Moore state register. Memory states are Mealy-gated by a memory-ready handshake. It sits beside the single-cycle main decoder and replaces it when the datapath shares one memory and one ALU across cycles.

## Interface
Parameters
- STATE_W, 4, width of the state/debug output

Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE
- mem_ready  in  1  memory has completed the current access this cycle
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load qualified by ALU zero, in the datapath
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data select: 1 = MDR
- regdst  out  1  destination register select: 1 = rd
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
- aluop  out  2  00 = add, 01 = sub, 10 = use funct
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
- state  out  STATE_W  current state, for debug

## Operation
State encodings:
- FETCH = 0
- DECODE = 1
- MEMADR = 2
- MEMRD = 3
- MEMWB = 4
- MEMWR = 5
- EXEC = 6
- ALUWB = 7
- BEQ = 8
- ADDIEX = 9
- ADDIWB = 10
- JUMP = 11

Outputs asserted per state; any output not listed is 0:
- FETCH: alusrcb=01. When mem_ready=1, also irwrite=1 and pcwrite=1. Go to DECODE on mem_ready, otherwise hold.
- DECODE: alusrcb=11. Branches on opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BEQ
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → illegal=1 and go to FETCH
- MEMADR: alusrca=1, alusrcb=10. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Go to MEMWB on mem_ready, otherwise hold.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
- MEMWR: iord=1, memwrite=1 (held for as long as the state holds). Go to FETCH on mem_ready, otherwise hold.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regwrite=1, regdst=1. Go to FETCH.
- BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Go to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Go to FETCH.

The opcode is sampled only in DECODE and in MEMADR (to choose between lw and sw). The instruction register holds it stable across those states.

## Timing
- State updates on the rising clk edge. Outputs are combinational from the state, plus mem_ready in FETCH.
- Reset: when rst_n=0 at an edge, state becomes FETCH. While rst_n=0, every write or enable output (pcwrite, branch, memwrite, irwrite, regwrite, illegal) is forced to 0. All selects read 0, except alusrcb, which reads 01 (the FETCH decode).
- Reset mid-instruction: the instruction is abandoned, with no partial writeback. After release, fetch restarts at the current PC.
- Cycle counts with mem_ready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No enable pulses during a stall except memwrite in MEMWR.
- illegal is high for exactly the DECODE cycle of an unsupported opcode.

## Configuration
- JUMP_EN defined: the JUMP state and opcode 000010 are supported as described above.
- JUMP_EN undefined: the JUMP state is not built. Opcode 000010 is treated as illegal (illegal pulse, return to FETCH). pcsrc never takes the value 10.

## Test plan
- Reset: hold rst_n=0 for 2 cycles in a mid-state, then release. Required: state=0, all enables 0 during reset, and irwrite=pcwrite=1 in the first FETCH cycle with mem_ready=1.
- lw (opcode 100011), mem_ready=1: state sequence 0,1,2,3,4,0. In state 4, regwrite=1 and memtoreg=1. Repeat with mem_ready low for 3 cycles in MEMRD: the sequence holds in state 3 for 3 extra cycles, so 8 cycles total.
- sw (101011): sequence 0,1,2,5,0. memwrite=1 and iord=1 only in state 5. regwrite is never set.
- R-type (000000) then beq (000100): R-type shows aluop=10 in EXEC and regwrite=1 with regdst=1 in ALUWB. beq shows branch=1, aluop=01, pcsrc=01 in state 8.
- Opcode 111111: sequence 0,1,0, with illegal=1 for the one DECODE cycle and no writes.
- j (000010):
  - with JUMP_EN: sequence 0,1,11,0, with pcwrite=1 and pcsrc=10 in state 11.
  - without JUMP_EN: the illegal pulse, and pcsrc never reads 10.
